// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with configurable response latency
// Optional feature macro: DMEM_ADDR_CHECK_EN (address/byte-enable checking with rsp_err reporting)
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // WAIT is unreachable when WAIT_CYCLES is 0, so the wrapped value is never compared
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              aerr_q, aerr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [IDX_W-1:0]  req_idx;
    logic              req_err;
    logic              accept;

    assign req_idx = req_addr[IDX_W+1:2];
    assign accept  = (state_q == IDLE) && req_valid;

`ifdef DMEM_ADDR_CHECK_EN
    assign req_err = (req_addr[1:0] != 2'b00)
                   || (req_addr >= 32'(4 * DEPTH_WORDS))
                   || (req_we && (req_be == 4'b0000));
`else
    // Only the word index matters; remaining address bits are deliberately ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
    assign req_err = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Next-state, wait counter and response capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        aerr_d  = aerr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    idx_d  = req_idx;
                    aerr_d = req_err;
                    cnt_d  = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        rdata_d = (req_we || req_err) ? 32'd0 : mem[req_idx];
                        err_d   = req_err;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    rdata_d = (we_q || aerr_q) ? 32'd0 : mem[idx_q];
                    err_d   = aerr_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            aerr_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            aerr_q  <= aerr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Stores commit at the acceptance edge; contents survive reset
    always_ff @(posedge clk) begin
        if (reset && accept && req_we && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with randomized traffic
module tb_dmem_responder;
    localparam int DW = 256;
    localparam int WC = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [DW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: applies the memory rules directly to a word array
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        int   idx;
        logic err;
`ifdef DMEM_ADDR_CHECK_EN
        err = (addr % 4 != 0) || (addr >= 4 * DW) || (we && be == 4'd0);
`else
        err = 1'b0;
`endif
        idx = int'((addr / 4) % DW);
        e.err = err;
        e.acc = cyc;
        if (we) begin
            e.rdata = 32'd0;
            if (!err) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            e.rdata = err ? 32'd0 : mdl[idx];
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard when a response appears, then watches it stay stable
    logic        have_cur = 1'b0;
    logic [31:0] cur_rdata;
    logic        cur_err;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            check("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
            if (!have_cur) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rdata %h err %0d want no response", rsp_rdata, rsp_err);
                end else begin
                    mon_e = sbq.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                    check("rsp_latency", 32'(cyc - mon_e.acc), 32'(WC + 1));
                end
                have_cur  = 1'b1;
                cur_rdata = rsp_rdata;
                cur_err   = rsp_err;
            end else begin
                check("hold_rdata", rsp_rdata, cur_rdata);
                check("hold_err", {31'd0, rsp_err}, {31'd0, cur_err});
            end
        end else begin
            have_cur = 1'b0;
        end
    end

    task automatic present(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, output logic ok);
        int g = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        ok = req_ready;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got req_ready 0 want 1");
            req_valid = 1'b0;
        end
    endtask

    task automatic scramble_inputs();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int bp);
        logic ok;
        int   g = 0;
        present(we, addr, wdata, be, ok);
        if (!ok) return;
        sbq.push_back(model(we, addr, wdata, be));
        @(posedge clk);
        #1 scramble_inputs();
        @(negedge clk);
        while (!rsp_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (!rsp_valid) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: got rsp_valid 0 want 1");
            return;
        end
        repeat (bp) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("done_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic        we;
        logic [31:0] addr;

        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_ready", {31'd0, req_ready}, 32'd1);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
        do_req(1'b1, 32'h10, 32'h000000AA, 4'h1, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 5);

        // Reset while a store is waiting: no response, store stays committed
        present(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, ok);
        if (ok) begin
            void'(model(1'b1, 32'h20, 32'hCAFEF00D, 4'hF));
            @(posedge clk);
            #1 scramble_inputs();
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("midrst_idle", {31'd0, req_ready}, 32'd1);
            reset = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("midrst_no_stale", {31'd0, rsp_valid}, 32'd0);
                check("midrst_ready", {31'd0, req_ready}, 32'd1);
            end
        end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, 1);

`ifdef DMEM_ADDR_CHECK_EN
        do_req(1'b0, 32'h402, 32'h0, 4'h0, 0);
        do_req(1'b1, 32'h400, 32'h55555555, 4'hF, 0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
`else
        do_req(1'b1, 32'h400, 32'h12345678, 4'hF, 0);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, 0);
`endif

        for (int i = 0; i < DW; i++)
            do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0);

        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom);
`ifdef DMEM_ADDR_CHECK_EN
            case ($urandom % 8)
                0: addr = $urandom;
                1: addr = 32'(($urandom % DW) * 4 + 1 + ($urandom % 3));
                default: addr = 32'(($urandom % DW) * 4);
            endcase
`else
            addr = $urandom;
`endif
            do_req(we, addr, $urandom, 4'($urandom), int'($urandom % 4));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit storage words (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning idle cycles between request acceptance and response (0..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, meaning reset; synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1, meaning responder can accept a request.
REQ-007 SHALL have port req_we, input, 1, meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, meaning byte address.
REQ-009 SHALL have port req_wdata, input, 32, meaning store data.
REQ-010 SHALL have port req_be, input, 4, meaning byte enables for stores; bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port rsp_valid, output, 1, meaning response present.
REQ-012 SHALL have port rsp_ready, input, 1, meaning initiator accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32, meaning load data; 0 for stores.
REQ-014 SHALL have port rsp_err, output, 1, meaning request was rejected.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready; IDLE -> WAIT if WAIT_CYCLES > 0, else IDLE -> RESP.
REQ-017 SHALL latch req_we, word index, req_wdata and req_be at acceptance; later input changes have no effect.
REQ-018 SHALL commit a valid store at the acceptance edge, writing only bytes with req_be bit set.
REQ-019 SHALL count exactly WAIT_CYCLES cycles in WAIT with a 4-bit counter, then move to RESP; rsp_valid first asserts WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-020 SHALL capture rsp_rdata for loads from memory on entry to RESP; the value reflects all stores committed earlier.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1; RESP -> IDLE on that edge.
REQ-022 SHALL NOT accept a new request in the cycle the response completes; at most one request is outstanding.
REQ-023 SHALL index memory by req_addr[log2(DEPTH_WORDS)+1:2].

Reset
REQ-024 SHALL, when reset = 0 at a rising edge, enter IDLE, clear the wait counter, and drive rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-025 SHALL NOT clear memory contents on reset.
REQ-026 SHALL drop any in-flight request on reset mid-operation without producing a response; a store committed at acceptance remains.
REQ-027 SHALL make req_ready = 1 on the first edge after reset returns high.

Configuration
REQ-028 SHALL honour macro DMEM_ADDR_CHECK_EN.
- Defined: rsp_err = 1 when req_addr[1:0] != 0, req_addr >= 4*DEPTH_WORDS, or a store has req_be = 0.
- Defined: an errored store writes nothing; an errored load returns rsp_rdata = 0.
- Undefined: addr[1:0] and upper address bits are ignored, the index wraps modulo DEPTH_WORDS, and rsp_err is tied to 0.

Verification
REQ-029 SHALL cover this case with WAIT_CYCLES = 1: store addr 0x10, data 0xDEADBEEF, be 0xF, then load 0x10 -> rsp_valid 2 cycles after each acceptance, load rdata = 0xDEADBEEF, err = 0.
REQ-030 SHALL cover a partial store: after the above, store addr 0x10, data 0x000000AA, be 0x1, then load -> rdata = 0xDEADBEAA.
REQ-031 SHALL cover backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rdata and err are stable and req_ready = 0 throughout; completion occurs on the first rsp_ready = 1.
REQ-032 SHALL cover reset mid-operation: assert reset = 0 in WAIT -> next cycle rsp_valid = 0 and state IDLE; after release req_ready = 1 with no stale response.
REQ-033 SHALL cover DMEM_ADDR_CHECK_EN defined with DEPTH_WORDS = 256: load 0x402 -> err = 1, rdata = 0; store 0x400 -> err = 1 and memory unchanged.
REQ-034 SHALL cover DMEM_ADDR_CHECK_EN undefined: store 0x400, data 0x12345678, then load 0x0 -> rdata = 0x12345678, err = 0 (wrap).
